// File: rtl/fpnew_rob_issuer.sv
// fpnew_rob_issuer: tags core requests, issues them to the FPU, reorders the
// out-of-order FPU results and retires them to the core in issue order.
module fpnew_rob_issuer #(
  parameter int unsigned Width       = 64,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned CtrlWidth   = 16,
  parameter int unsigned IdWidth     = 5,
  parameter int unsigned Depth       = 4,
  localparam int unsigned TagWidth   = $clog2(Depth)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  // core request
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [NumOperands*Width-1:0] req_operands_i,
  input  logic [CtrlWidth-1:0]         req_ctrl_i,
  input  logic [IdWidth-1:0]           req_id_i,
  // FPU input port
  output logic                         fpu_in_valid_o,
  input  logic                         fpu_in_ready_i,
  output logic [NumOperands*Width-1:0] fpu_operands_o,
  output logic [CtrlWidth-1:0]         fpu_ctrl_o,
  output logic [TagWidth-1:0]          fpu_tag_o,
  // FPU output port
  input  logic                         fpu_out_valid_i,
  output logic                         fpu_out_ready_o,
  input  logic [Width-1:0]             fpu_result_i,
  input  logic [4:0]                   fpu_status_i,
  input  logic [TagWidth-1:0]          fpu_tag_i,
  // in-order response
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [Width-1:0]             rsp_result_o,
  output logic [4:0]                   rsp_status_o,
  output logic [IdWidth-1:0]           rsp_id_o,
  // control / status
  input  logic                         flush_i,
  input  logic                         fflags_clr_i,
  output logic [4:0]                   fflags_o,
  output logic [TagWidth:0]            outstanding_o,
  output logic                         spurious_o,
  output logic                         busy_o
);

  localparam logic [TagWidth:0] PtrOne = 1;

  logic [TagWidth:0]    head_q, tail_q;
  logic [Depth-1:0]     alloc_q, done_q;
  logic [IdWidth-1:0]   id_q     [Depth];
  logic [Width-1:0]     result_q [Depth];
  logic [4:0]           status_q [Depth];
  logic [4:0]           fflags_q;
  logic                 spurious_q;

  logic [TagWidth-1:0]  head_idx, tail_idx;
  logic                 full;
  logic                 issue_fire, retire_fire;
  logic                 capture_hit, capture_ok, capture_drop;

  assign head_idx = head_q[TagWidth-1:0];
  assign tail_idx = tail_q[TagWidth-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[TagWidth] != tail_q[TagWidth]);

  // Issue path is a pure pass-through gated by free space and flush.
  assign fpu_in_valid_o = req_valid_i & ~full & ~flush_i;
  assign req_ready_o    = fpu_in_ready_i & ~full & ~flush_i;
  assign fpu_operands_o = req_operands_i;
  assign fpu_ctrl_o     = req_ctrl_i;
  assign fpu_tag_o      = tail_idx;
  assign issue_fire     = req_valid_i & req_ready_o;

  // Results are always accepted; the tag allocator guarantees a slot.
  assign fpu_out_ready_o = 1'b1;
  assign capture_hit     = alloc_q[fpu_tag_i] & ~done_q[fpu_tag_i];
  assign capture_ok      = fpu_out_valid_i & ~flush_i & capture_hit;
  assign capture_drop    = fpu_out_valid_i & ~flush_i & ~capture_hit;

  assign rsp_valid_o  = alloc_q[head_idx] & done_q[head_idx];
  assign rsp_result_o = result_q[head_idx];
  assign rsp_status_o = status_q[head_idx];
  assign rsp_id_o     = id_q[head_idx];
  assign retire_fire  = rsp_valid_o & rsp_ready_i & ~flush_i;

  assign fflags_o      = fflags_q;
  assign spurious_o    = spurious_q;
  assign outstanding_o = tail_q - head_q;
  assign busy_o        = |outstanding_o;

  // Pointers and per-entry alloc/done flags; flush overrides everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      alloc_q    <= '0;
      done_q     <= '0;
      spurious_q <= 1'b0;
    end else begin
      spurious_q <= capture_drop;
      if (issue_fire) begin
        alloc_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail_q            <= tail_q + PtrOne;
      end
      if (capture_ok) begin
        done_q[fpu_tag_i] <= 1'b1;
      end
      if (retire_fire) begin
        alloc_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head_q            <= head_q + PtrOne;
      end
    end
  end

  // Entry payloads need no reset: they are only read when alloc and done are set.
  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      id_q[tail_idx] <= req_id_i;
    end
    if (capture_ok) begin
      result_q[fpu_tag_i] <= fpu_result_i;
      status_q[fpu_tag_i] <= fpu_status_i;
    end
  end

  // Sticky exception flags; a clear coinciding with a retire keeps only that status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else if (retire_fire) begin
      fflags_q <= fflags_clr_i ? status_q[head_idx] : (fflags_q | status_q[head_idx]);
    end else if (fflags_clr_i) begin
      fflags_q <= '0;
    end
  end

endmodule

// File: tb/tb_fpnew_rob_issuer.sv
// Directed self-checking bench for fpnew_rob_issuer (Depth = 4).
module tb_fpnew_rob_issuer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [191:0] req_operands_i;
  logic [15:0]  req_ctrl_i;
  logic [4:0]   req_id_i;
  logic         fpu_in_valid_o;
  logic         fpu_in_ready_i;
  logic [191:0] fpu_operands_o;
  logic [15:0]  fpu_ctrl_o;
  logic [1:0]   fpu_tag_o;
  logic         fpu_out_valid_i;
  logic         fpu_out_ready_o;
  logic [63:0]  fpu_result_i;
  logic [4:0]   fpu_status_i;
  logic [1:0]   fpu_tag_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [63:0]  rsp_result_o;
  logic [4:0]   rsp_status_o;
  logic [4:0]   rsp_id_o;
  logic         flush_i;
  logic         fflags_clr_i;
  logic [4:0]   fflags_o;
  logic [2:0]   outstanding_o;
  logic         spurious_o;
  logic         busy_o;

  int vectors = 0;
  int miscompares = 0;

  fpnew_rob_issuer dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_operands_i  (req_operands_i),
    .req_ctrl_i      (req_ctrl_i),
    .req_id_i        (req_id_i),
    .fpu_in_valid_o  (fpu_in_valid_o),
    .fpu_in_ready_i  (fpu_in_ready_i),
    .fpu_operands_o  (fpu_operands_o),
    .fpu_ctrl_o      (fpu_ctrl_o),
    .fpu_tag_o       (fpu_tag_o),
    .fpu_out_valid_i (fpu_out_valid_i),
    .fpu_out_ready_o (fpu_out_ready_o),
    .fpu_result_i    (fpu_result_i),
    .fpu_status_i    (fpu_status_i),
    .fpu_tag_i       (fpu_tag_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_result_o    (rsp_result_o),
    .rsp_status_o    (rsp_status_o),
    .rsp_id_o        (rsp_id_o),
    .flush_i         (flush_i),
    .fflags_clr_i    (fflags_clr_i),
    .fflags_o        (fflags_o),
    .outstanding_o   (outstanding_o),
    .spurious_o      (spurious_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    #1;
  endtask

  // One-cycle request; checks the tag it is given.
  task automatic issue(input logic [4:0] id, input logic [1:0] exp_tag);
    req_valid_i    = 1'b1;
    req_id_i       = id;
    req_operands_i = {3{59'd0, id}};
    req_ctrl_i     = {11'd0, id};
    #1;
    chk("issue_tag", fpu_tag_o, exp_tag);
    chk("issue_ready", req_ready_o, 1'b1);
    chk("issue_fpu_valid", fpu_in_valid_o, 1'b1);
    chk("issue_ops", fpu_operands_o, {3{59'd0, id}});
    cyc();
    req_valid_i = 1'b0;
  endtask

  // One-cycle FPU result.
  task automatic ret(input logic [1:0] tag, input logic [63:0] res, input logic [4:0] st);
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = tag;
    fpu_result_i    = res;
    fpu_status_i    = st;
    cyc();
    fpu_out_valid_i = 1'b0;
  endtask

  // One-cycle retire with the expected head entry contents.
  task automatic retire(input logic [4:0] id, input logic [63:0] res, input logic [4:0] st);
    #1;
    chk("rsp_valid", rsp_valid_o, 1'b1);
    chk("rsp_id", rsp_id_o, id);
    chk("rsp_result", rsp_result_o, res);
    chk("rsp_status", rsp_status_o, st);
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    req_valid_i = 1'b0; req_operands_i = '0; req_ctrl_i = '0; req_id_i = '0;
    fpu_in_ready_i = 1'b1; fpu_out_valid_i = 1'b0; fpu_result_i = '0;
    fpu_status_i = '0; fpu_tag_i = '0; rsp_ready_i = 1'b0;
    flush_i = 1'b0; fflags_clr_i = 1'b0;

    // Reset state
    do_reset();
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 3'd0);
    chk("rst_fflags", fflags_o, 5'd0);
    chk("rst_spurious", spurious_o, 1'b0);
    chk("rst_out_ready", fpu_out_ready_o, 1'b1);

    // Single op
    issue(5'd3, 2'd0);
    chk("single_outst", outstanding_o, 3'd1);
    chk("single_busy", busy_o, 1'b1);
    cyc();
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0;
    fpu_result_i = 64'h3FF0000000000000; fpu_status_i = 5'b00001;
    #1;
    chk("single_no_comb", rsp_valid_o, 1'b0);
    cyc();
    fpu_out_valid_i = 1'b0;
    retire(5'd3, 64'h3FF0000000000000, 5'b00001);
    chk("single_fflags", fflags_o, 5'b00001);
    chk("single_empty", rsp_valid_o, 1'b0);
    chk("single_outst0", outstanding_o, 3'd0);
    chk("single_idle", busy_o, 1'b0);

    // Out of order
    do_reset();
    issue(5'd1, 2'd0);
    issue(5'd2, 2'd1);
    issue(5'd3, 2'd2);
    ret(2'd2, 64'hA2, 5'd0);
    chk("ooo_wait_head", rsp_valid_o, 1'b0);
    ret(2'd0, 64'hA0, 5'd0);
    chk("ooo_head_ready", rsp_valid_o, 1'b1);
    chk("ooo_head_id", rsp_id_o, 5'd1);
    // Capture tag 1 while retiring tag 0.
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; fpu_result_i = 64'hA1; fpu_status_i = 5'd0;
    rsp_ready_i = 1'b1;
    cyc();
    fpu_out_valid_i = 1'b0; rsp_ready_i = 1'b0;
    retire(5'd2, 64'hA1, 5'd0);
    retire(5'd3, 64'hA2, 5'd0);
    chk("ooo_drained", outstanding_o, 3'd0);

    // Full and pointer wrap
    do_reset();
    for (int k = 0; k < 4; k++) issue(5'(10 + k), k[1:0]);
    req_valid_i = 1'b1; req_id_i = 5'd14;
    #1;
    chk("full_ready", req_ready_o, 1'b0);
    chk("full_fpu_valid", fpu_in_valid_o, 1'b0);
    chk("full_outst", outstanding_o, 3'd4);
    ret(2'd0, 64'h1000, 5'd0);
    chk("full_still", outstanding_o, 3'd4);
    rsp_ready_i = 1'b1;
    #1;
    chk("full_retire_ready", req_ready_o, 1'b0);
    cyc();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("full_after_ret", outstanding_o, 3'd3);
    issue(5'd14, 2'd0);
    for (int k = 1; k < 4; k++) begin
      ret(k[1:0], 64'h1000 + 64'(k), 5'd0);
      retire(5'(10 + k), 64'h1000 + 64'(k), 5'd0);
      issue(5'(14 + k), k[1:0]);
    end
    req_valid_i = 1'b1;
    #1;
    chk("wrap_full_ready", req_ready_o, 1'b0);
    chk("wrap_outst", outstanding_o, 3'd4);
    req_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ret(k[1:0], 64'h2000 + 64'(k), 5'd0);
      retire(5'(14 + k), 64'h2000 + 64'(k), 5'd0);
    end
    chk("wrap_drained", outstanding_o, 3'd0);
    chk("wrap_tag", fpu_tag_o, 2'd0);

    // Flush
    do_reset();
    issue(5'd1, 2'd0);
    issue(5'd2, 2'd1);
    issue(5'd3, 2'd2);
    flush_i = 1'b1; req_valid_i = 1'b1; req_id_i = 5'd9;
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; fpu_result_i = 64'hF1; fpu_status_i = 5'd0;
    #1;
    chk("flush_fpu_valid", fpu_in_valid_o, 1'b0);
    chk("flush_req_ready", req_ready_o, 1'b0);
    cyc();
    flush_i = 1'b0; req_valid_i = 1'b0; fpu_out_valid_i = 1'b0;
    chk("flush_outst", outstanding_o, 3'd0);
    chk("flush_rsp", rsp_valid_o, 1'b0);
    chk("flush_spurious", spurious_o, 1'b0);
    chk("flush_busy", busy_o, 1'b0);
    issue(5'd4, 2'd0);
    ret(2'd0, 64'h44, 5'd0);
    retire(5'd4, 64'h44, 5'd0);

    // Spurious results
    do_reset();
    ret(2'd2, 64'hDEAD, 5'd0);
    chk("spur_pulse0", spurious_o, 1'b1);
    chk("spur_outst0", outstanding_o, 3'd0);
    cyc();
    chk("spur_clear", spurious_o, 1'b0);
    issue(5'd5, 2'd0);
    ret(2'd0, 64'hAAAA, 5'd1);
    chk("spur_good", spurious_o, 1'b0);
    ret(2'd0, 64'hBBBB, 5'd2);
    chk("spur_pulse1", spurious_o, 1'b1);
    chk("spur_outst1", outstanding_o, 3'd1);
    retire(5'd5, 64'hAAAA, 5'd1);

    // fflags accumulation and clear-with-retire
    do_reset();
    issue(5'd1, 2'd0);
    issue(5'd2, 2'd1);
    issue(5'd3, 2'd2);
    ret(2'd0, 64'h1, 5'b01000);
    ret(2'd1, 64'h2, 5'b00100);
    ret(2'd2, 64'h3, 5'b00010);
    retire(5'd1, 64'h1, 5'b01000);
    retire(5'd2, 64'h2, 5'b00100);
    chk("fflags_acc", fflags_o, 5'b01100);
    fflags_clr_i = 1'b1;
    retire(5'd3, 64'h3, 5'b00010);
    fflags_clr_i = 1'b0;
    chk("fflags_clr_ret", fflags_o, 5'b00010);
    fflags_clr_i = 1'b1;
    cyc();
    fflags_clr_i = 1'b0;
    chk("fflags_clr", fflags_o, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
